// File: rtl/vector_stream_engine.sv
// vector_stream_engine
//   Reads a programmable number of row pairs from a synchronous dual-read
//   matrix memory. Each pair is registered as operands, and one lane-wise
//   operation is applied to every lane. Each result row is streamed out on a
//   valid/ready port. After the last row, done pulses for one cycle.
//
//   Ports
//     clk, reset_n          clock; asynchronous active-low reset
//     start, op, base_a,    command; sampled only when idle
//     base_b, num_rows
//     busy, done            status; done is a single-cycle pulse
//     mem_en, mem_addr_a/b  memory read request; data returns one cycle later
//     mem_rdata_a/b         memory read data
//     res_valid/ready       result handshake
//     res_data, res_row     result row and its 0-based row index
//     sat_flag              (VSE_SATURATE_EN only) some lane of the row saturated
//
//   Build option
//     VSE_SATURATE_EN : add/sub saturate to the signed lane range and the
//                       sat_flag output is added. When the macro is undefined,
//                       add/sub wrap.
//
//   op: 00 add, 01 sub (a-b), 10 mul (low bits), 11 signed max (a on tie)

module vse_lane #(
  parameter int ELEM_WIDTH = 32
) (
  input  logic [1:0]            op,
  input  logic [ELEM_WIDTH-1:0] a,
  input  logic [ELEM_WIDTH-1:0] b,
  output logic [ELEM_WIDTH-1:0] y
`ifdef VSE_SATURATE_EN
  ,output logic                 sat
`endif
);
  logic [ELEM_WIDTH-1:0] max_ab;
  assign max_ab = ($signed(a) < $signed(b)) ? b : a;

`ifdef VSE_SATURATE_EN
  localparam logic [ELEM_WIDTH-1:0] MAX_POS = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
  localparam logic [ELEM_WIDTH-1:0] MIN_NEG = {1'b1, {(ELEM_WIDTH-1){1'b0}}};
  // One guard bit: the top two bits disagree exactly when the true result
  // is outside the lane range. The guard bit holds the true sign.
  logic [ELEM_WIDTH:0] sum_x, dif_x;

  always_comb begin
    sum_x = {a[ELEM_WIDTH-1], a} + {b[ELEM_WIDTH-1], b};
    dif_x = {a[ELEM_WIDTH-1], a} - {b[ELEM_WIDTH-1], b};
    y     = '0;
    sat   = 1'b0;
    unique case (op)
      2'b00: begin
        y = sum_x[ELEM_WIDTH-1:0];
        if (sum_x[ELEM_WIDTH] != sum_x[ELEM_WIDTH-1]) begin
          sat = 1'b1;
          y   = sum_x[ELEM_WIDTH] ? MIN_NEG : MAX_POS;
        end
      end
      2'b01: begin
        y = dif_x[ELEM_WIDTH-1:0];
        if (dif_x[ELEM_WIDTH] != dif_x[ELEM_WIDTH-1]) begin
          sat = 1'b1;
          y   = dif_x[ELEM_WIDTH] ? MIN_NEG : MAX_POS;
        end
      end
      2'b10:   y = a * b;
      default: y = max_ab;
    endcase
  end
`else
  always_comb begin
    y = '0;
    unique case (op)
      2'b00:   y = a + b;
      2'b01:   y = a - b;
      2'b10:   y = a * b;  // the low bits of a product do not depend on signedness
      default: y = max_ab;
    endcase
  end
`endif
endmodule

module vector_stream_engine #(
  parameter int ELEM_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [ADDR_W-1:0]           base_a,
  input  logic [ADDR_W-1:0]           base_b,
  input  logic [ADDR_W:0]             num_rows,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr_a,
  output logic [ADDR_W-1:0]           mem_addr_b,
  input  logic [ELEM_WIDTH*LANES-1:0] mem_rdata_a,
  input  logic [ELEM_WIDTH*LANES-1:0] mem_rdata_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ELEM_WIDTH*LANES-1:0] res_data,
  output logic [ADDR_W-1:0]           res_row
`ifdef VSE_SATURATE_EN
  ,output logic                       sat_flag
`endif
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] ROW_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]                            state_q, state_d;
  logic [1:0]                            op_q, op_d;
  logic [ADDR_W-1:0]                     base_a_q, base_a_d, base_b_q, base_b_d;
  logic [ADDR_W:0]                       num_rows_q, num_rows_d;
  logic [ADDR_W-1:0]                     row_q, row_d, row_nxt;
  logic [ADDR_W-1:0]                     addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [LANES-1:0][ELEM_WIDTH-1:0]      opa_q, opa_d, opb_q, opb_d;
  logic [LANES-1:0][ELEM_WIDTH-1:0]      res_q, res_d, lane_y;
  logic [ADDR_W-1:0]                     res_row_q, res_row_d;
  logic                                  last_row;
`ifdef VSE_SATURATE_EN
  logic [LANES-1:0]                      lane_sat;
  logic                                  sat_q, sat_d;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vse_lane #(.ELEM_WIDTH(ELEM_WIDTH)) u_lane (
      .op (op_q),
      .a  (opa_q[g]),
      .b  (opb_q[g]),
      .y  (lane_y[g])
`ifdef VSE_SATURATE_EN
      ,.sat(lane_sat[g])
`endif
    );
  end

  assign row_nxt  = row_q + ROW_ONE;
  assign last_row = ({1'b0, row_q} == (num_rows_q - CNT_ONE));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    num_rows_d = num_rows_q;
    row_d      = row_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    res_row_d  = res_row_q;
`ifdef VSE_SATURATE_EN
    sat_d      = sat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          base_a_d   = base_a;
          base_b_d   = base_b;
          num_rows_d = num_rows;
          row_d      = '0;
          if (num_rows == '0) begin
            state_d = S_DONE;
          end else begin
            // The address registers are loaded on entry to FETCH.
            // They keep their value afterwards, so the address outputs
            // hold their last value while the block is idle.
            addr_a_d = base_a;
            addr_b_d = base_b;
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        opa_d   = mem_rdata_a;
        opb_d   = mem_rdata_b;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        res_d     = lane_y;
        res_row_d = row_q;
`ifdef VSE_SATURATE_EN
        sat_d     = |lane_sat;
`endif
        state_d   = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (res_ready) begin
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d    = row_nxt;
            addr_a_d = base_a_q + row_nxt;  // wraps modulo 2^ADDR_W
            addr_b_d = base_b_q + row_nxt;
            state_d  = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      num_rows_q <= '0;
      row_q      <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      res_row_q  <= '0;
`ifdef VSE_SATURATE_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      num_rows_q <= num_rows_d;
      row_q      <= row_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_q      <= res_d;
      res_row_q  <= res_row_d;
`ifdef VSE_SATURATE_EN
      sat_q      <= sat_d;
`endif
    end
  end

  // All status outputs are decoded from the state register, so an
  // asynchronous reset clears them at once.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign mem_en     = (state_q == S_FETCH);
  assign res_valid  = (state_q == S_OUTPUT);
  assign mem_addr_a = addr_a_q;
  assign mem_addr_b = addr_b_q;
  assign res_data   = res_q;
  assign res_row    = res_row_q;
`ifdef VSE_SATURATE_EN
  assign sat_flag   = sat_q & (state_q == S_OUTPUT);
`endif
endmodule
